// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter types and frame constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter emitting one tick per CLKS_PER_BIT cycles
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A restart wins over a pending tick so a new frame always gets a full first bit
  assign bit_tick_o = (cnt_q == LAST) && !restart_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with registered line and done pulse
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_o_bus,
  output logic       isDone,
  output logic       bit_out
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        bit_out_q, bit_out_d;
  logic        done_q, done_d;
  logic        restart;
  logic        bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .bit_tick_o(bit_tick)
  );

  // Outputs are computed for the next state so the line is a pure flop output
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    bit_out_d = 1'b1;
    done_d    = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          shift_d   = data_o_bus;
          idx_d     = 3'd0;
          restart   = 1'b1;
          state_d   = START;
          bit_out_d = 1'b0;
        end
      end
      START: begin
        bit_out_d = 1'b0;
        if (bit_tick) begin
          state_d   = DATA;
          idx_d     = 3'd0;
          bit_out_d = shift_q[0];
        end
      end
      DATA: begin
        bit_out_d = shift_q[idx_q];
        if (bit_tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_out_d = 1'b1;
          end else begin
            idx_d     = idx_q + 3'd1;
            bit_out_d = shift_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      idx_q     <= 3'd0;
      bit_out_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      bit_out_q <= bit_out_d;
      done_q    <= done_d;
    end
  end

  assign bit_out = bit_out_q;
  assign isDone  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

  localparam int CPB = 10;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data;
  logic       is_done;
  logic       bit_out;

  int total;
  int bad;

  uart_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data_o_bus(data),
    .isDone    (is_done),
    .bit_out   (bit_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_bit(input logic [7:0] d, input int c);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    if (c < 1 || c > FRAME_CYC) return 1'b1;
    return frame[(c - 1) / CPB];
  endfunction

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      total++;
      if (bit_out !== 1'b1) begin
        bad++;
        $display("FAIL %s bit_out cycle=%0d got=%b exp=1", name, i, bit_out);
      end
      total++;
      if (is_done !== 1'b0) begin
        bad++;
        $display("FAIL %s isDone cycle=%0d got=%b exp=0", name, i, is_done);
      end
    end
  endtask

  // Checks every cycle of one frame plus the done pulse and one trailing idle cycle
  task automatic run_frame(input string name, input logic [7:0] d,
                           input int en_cycles, input bit mutate);
    logic exp_bit;
    logic exp_done;
    @(negedge clk);
    enable = 1'b1;
    data   = d;
    for (int c = 1; c <= FRAME_CYC + 2; c++) begin
      @(negedge clk);
      exp_bit  = model_bit(d, c);
      exp_done = (c == FRAME_CYC + 1);
      total++;
      if (bit_out !== exp_bit) begin
        bad++;
        $display("FAIL %s bit_out data=%h cycle=%0d got=%b exp=%b", name, d, c, bit_out, exp_bit);
      end
      total++;
      if (is_done !== exp_done) begin
        bad++;
        $display("FAIL %s isDone data=%h cycle=%0d got=%b exp=%b", name, d, c, is_done, exp_done);
      end
      enable = (c < en_cycles);
      if (mutate && c == 35) data = 8'hFF;
    end
    enable = 1'b0;
  endtask

  task automatic test_reset;
    rst    = 1'b0;
    enable = 1'b0;
    data   = 8'h00;
    check_idle("reset_hold", 3);
    rst = 1'b1;
    check_idle("reset_release", 5);
  endtask

  task automatic test_single;
    run_frame("single_48", 8'h48, 1, 1'b0);
    check_idle("single_after", 3);
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_6f", 8'h6F, 1, 1'b0);
    run_frame("b2b_6c", 8'h6C, 1, 1'b0);
    run_frame("b2b_61", 8'h61, 1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    run_frame("busy_48", 8'h48, 3, 1'b1);
    check_idle("busy_after", 5);
  endtask

  task automatic test_done_ignore;
    logic [7:0] d;
    d = 8'h3C;
    @(negedge clk);
    enable = 1'b1;
    data   = d;
    for (int c = 1; c <= FRAME_CYC + 1; c++) begin
      @(negedge clk);
      total++;
      if (bit_out !== model_bit(d, c)) begin
        bad++;
        $display("FAIL done_ignore bit_out cycle=%0d got=%b exp=%b", c, bit_out, model_bit(d, c));
      end
      enable = (c == FRAME_CYC + 1);
    end
    total++;
    if (is_done !== 1'b1) begin
      bad++;
      $display("FAIL done_ignore isDone got=%b exp=1", is_done);
    end
    @(posedge clk);
    #1 enable = 1'b0;
    check_idle("done_ignore_after", 4);
  endtask

  task automatic test_mid_reset;
    logic [7:0] d;
    d = 8'hB6;
    @(negedge clk);
    enable = 1'b1;
    data   = d;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      enable = 1'b0;
      total++;
      if (bit_out !== model_bit(d, c)) begin
        bad++;
        $display("FAIL mid_reset pre bit_out cycle=%0d got=%b exp=%b", c, bit_out, model_bit(d, c));
      end
    end
    rst = 1'b0;
    check_idle("mid_reset_hold", 2);
    rst = 1'b1;
    check_idle("mid_reset_after", FRAME_CYC + 5);
    run_frame("mid_reset_new", 8'h5A, 1, 1'b0);
  endtask

  task automatic test_param_a5;
    run_frame("param_a5", 8'hA5, 1, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] d;
    int en;
    int gap;
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      en  = int'($urandom_range(1, 3));
      gap = int'($urandom_range(0, 4));
      run_frame("random", d, en, 1'b0);
      check_idle("random_gap", gap);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    enable = 1'b0;
    data   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_done_ignore();
    test_mid_reset();
    test_param_a5();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
